// File: rtl/wdata_memory_pkg.sv
// -----------------------------------------------------------------------------
// wdata_memory_pkg
// Shared DSP constants and types for the write-side data memory and its
// read-side counterpart.
//   DSP_DATA_W : default operand word width
//   DSP_DEPTH  : default entries per bank
//   state_t    : write-side FSM states (IDLE / WRITE / FULL)
// -----------------------------------------------------------------------------
package wdata_memory_pkg;

  localparam int DSP_DATA_W = 32;
  localparam int DSP_DEPTH  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/wdata_memory_if.sv
// -----------------------------------------------------------------------------
// wdata_memory_if
// Operand-pair write handshake plus the registered read port.
//   wr_valid, wr_ready       : valid/ready handshake for one pair per beat
//   write_data1, write_data2 : operand pair (bank 1 / bank 2)
//   rd_addr                  : read address
//   read_data1, read_data2   : registered read data (bank 1 / bank 2)
// master = producer/consumer side, slave = the memory.
// -----------------------------------------------------------------------------
interface wdata_memory_if
  import wdata_memory_pkg::*;
#(
  parameter int DATA_W = DSP_DATA_W,
  parameter int ADDR_W = $clog2(DSP_DEPTH)
);

  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] write_data1;
  logic [DATA_W-1:0] write_data2;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;

  modport master (
    output wr_valid, write_data1, write_data2, rd_addr,
    input  wr_ready, read_data1, read_data2
  );

  modport slave (
    input  wr_valid, write_data1, write_data2, rd_addr,
    output wr_ready, read_data1, read_data2
  );

endinterface

// File: rtl/wdata_bank.sv
// -----------------------------------------------------------------------------
// wdata_bank
// Single DEPTH x DATA_W storage bank with a synchronous write port and a
// registered read port. The array itself is not reset; the read register is.
//   clk, rst         : clock, synchronous active-high reset
//   wr_en, wr_addr,
//   wr_data          : write port
//   rd_en, rd_addr   : read request; rd_en=0 yields zero on rd_data
//   rd_data          : registered read data
// -----------------------------------------------------------------------------
module wdata_bank #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Storage write; contents are meaningful only where the owner says so.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read; an invalid request reads as zero rather than stale data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= {DATA_W{1'b0}};
    end else if (rd_en) begin
      rd_data <= mem_r[rd_addr];
    end else begin
      rd_data <= {DATA_W{1'b0}};
    end
  end

endmodule

// File: rtl/wdata_memory.sv
// -----------------------------------------------------------------------------
// wdata_memory
// Write-side DSP data memory. Accepts operand pairs over a valid/ready
// handshake and stores them in two parallel banks at an auto-incrementing
// address; flags full/done when all DEPTH entries are written.
//   clk, rst  : clock, synchronous active-high reset
//   enable    : arms writing; low pauses (WRITE) or clears and rearms (FULL)
//   bus       : wdata_memory_if.slave (write handshake + registered read port)
//   wr_count  : pairs stored, 0..DEPTH
//   full      : buffer complete
//   done      : one-cycle pulse on completion
// -----------------------------------------------------------------------------
module wdata_memory
  import wdata_memory_pkg::*;
#(
  parameter  int DATA_W = DSP_DATA_W,
  parameter  int DEPTH  = DSP_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  wdata_memory_if.slave      bus,
  output logic [ADDR_W:0]    wr_count,
  output logic               full,
  output logic               done
);

  localparam logic [ADDR_W:0] CNT_ZERO = (ADDR_W+1)'(0);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

  state_t          state_r;
  logic [ADDR_W:0] count_r;
  logic            full_r;
  logic            done_r;

  logic            ready_s;
  logic            accept_s;
  logic            bank_wr_en_s;
  logic            rd_valid_s;

  // Handshake decode: ready never looks at wr_valid; reset drops any accept.
  always_comb begin
    ready_s      = 1'b0;
    accept_s     = 1'b0;
    bank_wr_en_s = 1'b0;
    rd_valid_s   = 1'b0;
    if (state_r == WRITE) begin
      ready_s = enable;
    end else begin
      ready_s = 1'b0;
    end
    accept_s     = ready_s & bus.wr_valid;
    bank_wr_en_s = accept_s & ~rst;
    // Compare against the pre-edge count so the entry being written this
    // cycle still reads as zero.
    rd_valid_s   = ({1'b0, bus.rd_addr} < count_r);
  end

  // Control FSM with write counter and registered full/done flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      count_r <= CNT_ZERO;
      full_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          full_r <= 1'b0;
          if (enable) begin
            state_r <= WRITE;
          end else begin
            state_r <= IDLE;
          end
        end
        WRITE: begin
          if (!enable) begin
            // Pause: count is held so writing resumes at the same address.
            state_r <= IDLE;
            full_r  <= 1'b0;
          end else if (accept_s) begin
            count_r <= count_r + CNT_ONE;
            if (count_r == LAST_IDX) begin
              state_r <= FULL;
              full_r  <= 1'b1;
              done_r  <= 1'b1;
            end else begin
              state_r <= WRITE;
              full_r  <= 1'b0;
            end
          end else begin
            state_r <= WRITE;
            full_r  <= 1'b0;
          end
        end
        FULL: begin
          if (!enable) begin
            // Leaving FULL discards the buffer and rearms from address 0.
            state_r <= IDLE;
            count_r <= CNT_ZERO;
            full_r  <= 1'b0;
          end else begin
            state_r <= FULL;
            full_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          count_r <= CNT_ZERO;
          full_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wr_ready = ready_s;
  assign wr_count     = count_r;
  assign full         = full_r;
  assign done         = done_r;

  wdata_bank #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_bank1 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bank_wr_en_s),
    .wr_addr (count_r[ADDR_W-1:0]),
    .wr_data (bus.write_data1),
    .rd_en   (rd_valid_s),
    .rd_addr (bus.rd_addr),
    .rd_data (bus.read_data1)
  );

  wdata_bank #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_bank2 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bank_wr_en_s),
    .wr_addr (count_r[ADDR_W-1:0]),
    .wr_data (bus.write_data2),
    .rd_en   (rd_valid_s),
    .rd_addr (bus.rd_addr),
    .rd_data (bus.read_data2)
  );

endmodule
